sie_ignition_detector: RTL and testbench
========================================

# sie_ignition_detector

Temporal event detector placed directly downstream of the Kuramoto order-parameter stage. It samples the population synchrony metric R on each update strobe and applies onset debounce, hysteresis, a maximum-duration timeout and a refractory lockout. From this it produces SIE (synchrony ignition event) pulses, a sustained ignition flag that drives the coupling-mode switch (modulatory vs harmonic), and per-event statistics (duration, peak R, event count) for state characterization.

## Interface
Parameters:
- WIDTH, 18, data width of R and peak outputs (signed Q14)
- FRAC, 14, fractional bits
- ON_THRESH, 11469, ignition entry threshold (0.7 in Q14)
- OFF_THRESH, 9830, ignition exit threshold (0.6 in Q14); must be < ON_THRESH
- ONSET_SAMPLES, 8, consecutive samples ≥ ON_THRESH required to ignite; must be ≥ 2
- MAX_DUR, 4000, samples after which an ignition is force-terminated
- REFRACTORY, 64, lockout length in samples after any ignition end
- CNT_W, 16, width of the duration and event counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  sample strobe, shared with the upstream order-parameter stage
- detect_en  in  1  detector enable; low forces the FSM toward IDLE
- kuramoto_R  in  WIDTH signed  order parameter, Q14
- ignition_pulse  out  1  one-clk pulse on ignition onset
- ignition_end  out  1  one-clk pulse on ignition termination (any cause)
- timeout  out  1  one-clk pulse, coincident with ignition_end, when the end was caused by MAX_DUR
- ignition_active  out  1  high while in IGNITED
- coupling_mode  out  1  1 = harmonic (equals ignition_active), 0 = modulatory
- fsm_state  out  2  0 IDLE, 1 ARMING, 2 IGNITED, 3 REFRACT
- event_count  out  CNT_W  ignitions since reset; saturates at all-ones
- last_duration  out  CNT_W  length in samples of the most recent completed ignition
- last_peak_R  out  WIDTH signed  maximum R during the most recent completed ignition

## Operation
- All state advances only on cycles with clk_en=1. With clk_en=0, everything holds except the pulse outputs, which clear.
- R comparisons are signed. Negative R counts as below both thresholds.
- IDLE:
  - R ≥ ON_THRESH: go to ARMING, onset_cnt=1.
  - Otherwise stay in IDLE.
- ARMING:
  - R < ON_THRESH: go to IDLE, onset_cnt=0.
  - Otherwise onset_cnt+1. When that value equals ONSET_SAMPLES: go to IGNITED, assert ignition_pulse, increment event_count (saturating), set dur_cnt=1, set peak=R.
- IGNITED:
  - Exit condition: R < OFF_THRESH. Go to REFRACT, assert ignition_end, load last_duration=dur_cnt and last_peak_R=peak.
  - Hysteresis: R in [OFF_THRESH, ON_THRESH) keeps the block in IGNITED.
  - Otherwise: dur_cnt+1 and peak=max(peak,R).
  - If dur_cnt reaches MAX_DUR (checked before the R test), exit as above and also assert timeout.
  - last_peak_R takes the peak including the current sample only on non-exit samples. On an exit sample the current R is excluded.
- REFRACT:
  - refr_cnt counts REFRACTORY samples, then the FSM goes to IDLE.
  - R is ignored throughout; no arming is possible.
- detect_en=0, sampled on clk_en:
  - From IDLE, ARMING or REFRACT: go to IDLE, clearing onset_cnt and refr_cnt.
  - From IGNITED: perform the normal termination (ignition_end, capture statistics), then go to IDLE without refractory.
  - detect_en takes priority over all other transitions.
- Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Reset values: fsm_state=IDLE, all pulses 0, ignition_active=0, coupling_mode=0, event_count=0, last_duration=0, last_peak_R=0. All internal counters are 0.
- Pulses rise at the clk_en edge that causes the transition and fall at the next clk edge. Each pulse is exactly one clk wide, regardless of clk_en spacing.
- Onset latency: if R ≥ ON_THRESH on samples k..k+ONSET_SAMPLES−1, ignition_pulse, ignition_active and coupling_mode are asserted after the clk_en edge of sample k+ONSET_SAMPLES−1.
- Termination: ignition_active falls on the same edge that ignition_end rises. last_duration and last_peak_R are valid from that edge.
- Upstream R is registered one clk_en behind its inputs. The one-sample lag is inherent and is not compensated here.
- Asynchronous reset mid-event immediately clears all outputs. No ignition_end is emitted.

## Test plan
- R=12000 for 8 samples: ignition_pulse after the 8th clk_en; event_count=1, fsm_state=2, coupling_mode=1.
- R=12000 for 7 samples, then 11000, then 12000 for 8 samples: no pulse through the first 8 samples and fsm_state returns to 0; ignition occurs on the 16th sample.
- Ignite; R=10000 for 20 samples; R=15000 once; R=9000: still IGNITED through the hysteresis band. ignition_end on the 9000 sample with last_duration=22, last_peak_R=15000. Then with R=16384 held, fsm_state=3 for 64 samples, returns to 0, and re-ignites after 8 more samples.
- MAX_DUR=10, R held at 16000: ignition_end and timeout pulse together with last_duration=10, followed by REFRACT.
- Drop detect_en during IGNITED: ignition_end with statistics captured and fsm_state=0 directly. Assert rst mid-ARMING: all outputs are 0 within the same cycle.
- clk_en low for 5 clks between samples: state holds and each pulse is exactly one clk wide. event_count saturates at 65535 under repeated short ignitions.

Source files
------------

// File: rtl/sie_ignition_detector.sv
// Synchrony ignition event detector: debounced onset, hysteretic exit, duration
// timeout and refractory lockout on the Kuramoto order parameter R.
module sie_ignition_detector #(
  parameter int WIDTH         = 18,
  parameter int FRAC          = 14,
  parameter int ON_THRESH     = 11469,
  parameter int OFF_THRESH    = 9830,
  parameter int ONSET_SAMPLES = 8,
  parameter int MAX_DUR       = 4000,
  parameter int REFRACTORY    = 64,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    detect_en,
  input  logic signed [WIDTH-1:0] kuramoto_R,
  output logic                    ignition_pulse,
  output logic                    ignition_end,
  output logic                    timeout,
  output logic                    ignition_active,
  output logic                    coupling_mode,
  output logic [1:0]              fsm_state,
  output logic [CNT_W-1:0]        event_count,
  output logic [CNT_W-1:0]        last_duration,
  output logic signed [WIDTH-1:0] last_peak_R
);

  localparam int ONS_W = $clog2(ONSET_SAMPLES + 1);
  localparam int REF_W = $clog2(REFRACTORY + 2);
  localparam logic signed [WIDTH-1:0] ON_C    = WIDTH'(ON_THRESH);
  localparam logic signed [WIDTH-1:0] OFF_C   = WIDTH'(OFF_THRESH);
  localparam logic [ONS_W-1:0]        ONSET_C = ONS_W'(ONSET_SAMPLES);
  localparam logic [REF_W-1:0]        REFR_C  = REF_W'(REFRACTORY);
  localparam logic [CNT_W-1:0]        MAXD_C  = CNT_W'(MAX_DUR);

  if (FRAC >= WIDTH || OFF_THRESH >= ON_THRESH || ONSET_SAMPLES < 2) begin : g_param_check
    $error("sie_ignition_detector: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_IGN  = 2'd2,
    S_REF  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic signed [WIDTH-1:0] max_r(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return (b > a) ? b : a;
  endfunction

  state_t                  state_q, state_d;
  logic [ONS_W-1:0]        onset_q, onset_d, onset_inc;
  logic [REF_W-1:0]        refr_q, refr_d, refr_inc;
  logic [CNT_W-1:0]        dur_q, dur_d;
  logic signed [WIDTH-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]        evt_q, evt_d;
  logic [CNT_W-1:0]        last_dur_q, last_dur_d;
  logic signed [WIDTH-1:0] last_peak_q, last_peak_d;
  logic                    pulse_q, pulse_d, end_q, end_d, to_q, to_d, active_q, active_d;
  logic                    ge_on, below_off, dur_hit;

  assign ge_on     = (kuramoto_R >= ON_C);
  assign below_off = (kuramoto_R < OFF_C);
  assign dur_hit   = (dur_q >= MAXD_C);
  assign onset_inc = onset_q + ONS_W'(1);
  assign refr_inc  = refr_q + REF_W'(1);

  always_comb begin
    state_d     = state_q;
    onset_d     = onset_q;
    refr_d      = refr_q;
    dur_d       = dur_q;
    peak_d      = peak_q;
    evt_d       = evt_q;
    last_dur_d  = last_dur_q;
    last_peak_d = last_peak_q;
    pulse_d     = 1'b0;
    end_d       = 1'b0;
    to_d        = 1'b0;
    if (clk_en) begin
      if (!detect_en) begin
        // Disable terminates a live ignition but skips the refractory lockout.
        state_d = S_IDLE;
        onset_d = '0;
        refr_d  = '0;
        if (state_q == S_IGN) begin
          end_d       = 1'b1;
          last_dur_d  = dur_q;
          last_peak_d = peak_q;
          dur_d       = '0;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (ge_on) begin
              state_d = S_ARM;
              onset_d = ONS_W'(1);
            end
          end
          S_ARM: begin
            if (!ge_on) begin
              state_d = S_IDLE;
              onset_d = '0;
            end else if (onset_inc == ONSET_C) begin
              state_d = S_IGN;
              onset_d = '0;
              pulse_d = 1'b1;
              evt_d   = sat_inc(evt_q);
              dur_d   = CNT_W'(1);
              peak_d  = kuramoto_R;
            end else begin
              onset_d = onset_inc;
            end
          end
          S_IGN: begin
            // Timeout outranks the level test; the exit sample never enters the peak.
            if (dur_hit || below_off) begin
              state_d     = S_REF;
              end_d       = 1'b1;
              to_d        = dur_hit;
              last_dur_d  = dur_q;
              last_peak_d = peak_q;
              dur_d       = '0;
              refr_d      = '0;
            end else begin
              dur_d  = sat_inc(dur_q);
              peak_d = max_r(peak_q, kuramoto_R);
            end
          end
          S_REF: begin
            if (refr_inc >= REFR_C) begin
              state_d = S_IDLE;
              refr_d  = '0;
            end else begin
              refr_d = refr_inc;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
    active_d = (state_d == S_IGN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      onset_q     <= '0;
      refr_q      <= '0;
      dur_q       <= '0;
      peak_q      <= '0;
      evt_q       <= '0;
      last_dur_q  <= '0;
      last_peak_q <= '0;
      pulse_q     <= 1'b0;
      end_q       <= 1'b0;
      to_q        <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      onset_q     <= onset_d;
      refr_q      <= refr_d;
      dur_q       <= dur_d;
      peak_q      <= peak_d;
      evt_q       <= evt_d;
      last_dur_q  <= last_dur_d;
      last_peak_q <= last_peak_d;
      pulse_q     <= pulse_d;
      end_q       <= end_d;
      to_q        <= to_d;
      active_q    <= active_d;
    end
  end

  assign ignition_pulse  = pulse_q;
  assign ignition_end    = end_q;
  assign timeout         = to_q;
  assign ignition_active = active_q;
  assign coupling_mode   = active_q;
  assign fsm_state       = state_q;
  assign event_count     = evt_q;
  assign last_duration   = last_dur_q;
  assign last_peak_R     = last_peak_q;

endmodule

// File: tb/tb_sie_ignition_detector.sv
// Directed bench: default-parameter detector plus a short-timeout, narrow-counter
// instance for the MAX_DUR and event-count saturation cases.
module tb_sie_ignition_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;
  logic detect_en = 1'b1;
  logic signed [17:0] r_in = '0;

  logic a_pulse, a_end, a_to, a_act, a_cm;
  logic [1:0] a_fsm;
  logic [15:0] a_evt, a_dur;
  logic signed [17:0] a_peak;

  logic b_pulse, b_end, b_to, b_act, b_cm;
  logic [1:0] b_fsm;
  logic [3:0] b_evt, b_dur;
  logic signed [17:0] b_peak;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sie_ignition_detector u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .detect_en(detect_en), .kuramoto_R(r_in),
    .ignition_pulse(a_pulse), .ignition_end(a_end), .timeout(a_to),
    .ignition_active(a_act), .coupling_mode(a_cm), .fsm_state(a_fsm),
    .event_count(a_evt), .last_duration(a_dur), .last_peak_R(a_peak)
  );

  sie_ignition_detector #(.MAX_DUR(10), .CNT_W(4), .ONSET_SAMPLES(2), .REFRACTORY(3)) u_dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .detect_en(detect_en), .kuramoto_R(r_in),
    .ignition_pulse(b_pulse), .ignition_end(b_end), .timeout(b_to),
    .ignition_active(b_act), .coupling_mode(b_cm), .fsm_state(b_fsm),
    .event_count(b_evt), .last_duration(b_dur), .last_peak_R(b_peak)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample: strobe clk_en for a single clock, then look 1 time unit later.
  task automatic step(input int r);
    r_in   = 18'(r);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    clk_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fsm", a_fsm, 0);
    chk("rst_evt", a_evt, 0);
    chk("rst_dur", a_dur, 0);
    chk("rst_peak", a_peak, 0);
    chk("rst_act", a_act, 0);
    chk("rst_pulse", a_pulse, 0);
    rst = 1'b0;

    step(-12000);
    chk("neg_idle", a_fsm, 0);

    // Clean onset: 8 samples at 0.73
    for (int i = 0; i < 7; i++) step(12000);
    chk("arm_fsm", a_fsm, 1);
    chk("arm_nopulse", a_pulse, 0);
    step(12000);
    chk("ign_pulse", a_pulse, 1);
    chk("ign_act", a_act, 1);
    chk("ign_cm", a_cm, 1);
    chk("ign_fsm", a_fsm, 2);
    chk("ign_evt", a_evt, 1);

    // Hysteresis band, one new peak, then exit
    for (int i = 0; i < 20; i++) step(10000);
    step(15000);
    chk("hyst_fsm", a_fsm, 2);
    chk("hyst_pulse_clr", a_pulse, 0);
    step(9000);
    chk("exit_end", a_end, 1);
    chk("exit_to", a_to, 0);
    chk("exit_act", a_act, 0);
    chk("exit_fsm", a_fsm, 3);
    chk("exit_dur", a_dur, 22);
    chk("exit_peak", a_peak, 15000);

    for (int i = 0; i < 63; i++) step(16384);
    chk("refr_hold", a_fsm, 3);
    chk("refr_end_clr", a_end, 0);
    step(16384);
    chk("refr_done", a_fsm, 0);
    for (int i = 0; i < 7; i++) step(16384);
    chk("rearm_fsm", a_fsm, 1);
    step(16384);
    chk("reign_pulse", a_pulse, 1);
    chk("reign_evt", a_evt, 2);

    // Disable during ignition: terminate without refractory
    step(16384);
    step(16384);
    detect_en = 1'b0;
    step(5000);
    chk("dis_end", a_end, 1);
    chk("dis_to", a_to, 0);
    chk("dis_fsm", a_fsm, 0);
    chk("dis_act", a_act, 0);
    chk("dis_dur", a_dur, 3);
    chk("dis_peak", a_peak, 16384);
    detect_en = 1'b1;

    // Broken onset restarts the debounce
    for (int i = 0; i < 7; i++) begin
      step(12000);
      chk("brk_nopulse1", a_pulse, 0);
    end
    step(11000);
    chk("brk_idle", a_fsm, 0);
    for (int i = 0; i < 7; i++) begin
      step(12000);
      chk("brk_nopulse2", a_pulse, 0);
    end
    chk("brk_arm", a_fsm, 1);
    step(12000);
    chk("brk_pulse", a_pulse, 1);
    chk("brk_evt", a_evt, 3);

    // Sparse strobes: pulses last one clock, state holds
    idle_clks(1);
    chk("gap_pulse_w", a_pulse, 0);
    idle_clks(4);
    chk("gap_fsm", a_fsm, 2);
    chk("gap_evt", a_evt, 3);
    step(5000);
    chk("gap_end", a_end, 1);
    chk("gap_dur", a_dur, 1);
    chk("gap_peak", a_peak, 12000);
    idle_clks(1);
    chk("gap_end_w", a_end, 0);
    chk("gap_refr", a_fsm, 3);

    // Asynchronous reset in ARMING
    detect_en = 1'b0;
    step(0);
    detect_en = 1'b1;
    for (int i = 0; i < 3; i++) step(12000);
    chk("pre_rst_arm", a_fsm, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_fsm", a_fsm, 0);
    chk("arst_evt", a_evt, 0);
    chk("arst_dur", a_dur, 0);
    chk("arst_peak", a_peak, 0);
    chk("arst_act", a_act, 0);
    chk("arst_cm", a_cm, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Short-timeout instance: forced termination
    step(16000);
    step(16000);
    chk("b_pulse", b_pulse, 1);
    chk("b_fsm_ign", b_fsm, 2);
    chk("b_evt", b_evt, 1);
    for (int i = 0; i < 9; i++) step(16000);
    chk("b_pre_to_fsm", b_fsm, 2);
    chk("b_pre_to_end", b_end, 0);
    step(16000);
    chk("b_to_end", b_end, 1);
    chk("b_to_to", b_to, 1);
    chk("b_to_dur", b_dur, 10);
    chk("b_to_peak", b_peak, 16000);
    chk("b_to_fsm", b_fsm, 3);
    step(16000);
    step(16000);
    chk("b_refr", b_fsm, 3);
    step(16000);
    chk("b_refr_done", b_fsm, 0);

    // Event counter saturation (4-bit)
    for (int k = 0; k < 14; k++) begin
      step(16000);
      step(16000);
      detect_en = 1'b0;
      step(0);
      detect_en = 1'b1;
    end
    chk("b_evt_full", b_evt, 15);
    step(16000);
    step(16000);
    chk("b_sat_pulse", b_pulse, 1);
    chk("b_evt_sat", b_evt, 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
